// File: rtl/sata_oob_pkg.sv
// Constants and types shared by the SATA OOB transmit encoder and the OOB
// receive decoder: OOB timing in UI, the ALIGN primitive and the sequence kind.
package sata_oob_pkg;

  localparam int REFFREQ    = 1_500_000;
  localparam int UI_BURST   = 160;
  localparam int UI_GAPINIT = 480;
  localparam int UI_GAPWAKE = 160;
  localparam int AMOUNT_DEF = 6;

  localparam logic [31:0] ALIGN_DATA  = 32'h7B4A_4ABC;
  localparam logic [3:0]  ALIGN_DATAK = 4'b0001;

  typedef enum logic {
    KIND_INIT = 1'b0,
    KIND_WAKE = 1'b1
  } oob_kind_t;

  // Convert a duration in UI into clk cycles, rounded to nearest.
  function automatic int ui_to_cycles(input int ui, input int clkfreq);
    longint prod;
    prod = longint'(ui) * longint'(clkfreq) + longint'(REFFREQ / 2);
    return int'(prod / longint'(REFFREQ));
  endfunction

endpackage

// File: rtl/sata_oob_encoder.sv
// SATA OOB transmit sequencer: emits AMOUNT burst/gap pairs for COMINIT/COMRESET
// or COMWAKE, driving ALIGN during bursts and electrical idle during gaps.
module sata_oob_encoder
  import sata_oob_pkg::*;
#(
  parameter int CLKFREQ = 150_000,
  parameter int AMOUNT  = AMOUNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cominit_req,
  input  logic        comwake_req,
  output logic        busy,
  output logic        done,
  output logic        tx_elecidle,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_datak
);

  localparam int BURST_LEN   = ui_to_cycles(UI_BURST, CLKFREQ);
  localparam int GAPINIT_LEN = ui_to_cycles(UI_GAPINIT, CLKFREQ);
  localparam int GAPWAKE_LEN = ui_to_cycles(UI_GAPWAKE, CLKFREQ);
  localparam int LEN_W       = $clog2(GAPINIT_LEN + 1);
  localparam int PAIR_W      = (AMOUNT > 1) ? $clog2(AMOUNT) : 1;

  localparam logic [LEN_W-1:0]  BURST_LAST   = LEN_W'(BURST_LEN - 1);
  localparam logic [LEN_W-1:0]  GAPINIT_LAST = LEN_W'(GAPINIT_LEN - 1);
  localparam logic [LEN_W-1:0]  GAPWAKE_LAST = LEN_W'(GAPWAKE_LEN - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST    = PAIR_W'(AMOUNT - 1);

  if (BURST_LEN < 1 || GAPINIT_LEN < 1 || GAPWAKE_LEN < 1 || AMOUNT < 1) begin : g_bad_params
    $error("sata_oob_encoder: CLKFREQ/AMOUNT give a zero-length OOB interval");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  oob_kind_t         kind_q, kind_d;
  logic              start_q, start_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              done_d;
  logic [LEN_W-1:0]  gap_last;

  assign gap_last = (kind_q == KIND_INIT) ? GAPINIT_LAST : GAPWAKE_LAST;

  // start_q holds an accepted request for one cycle so the kind register is
  // settled before the first burst begins.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    start_d = 1'b0;
    len_d   = len_q;
    pair_d  = pair_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_BURST;
          len_d   = '0;
        end else if (cominit_req || comwake_req) begin
          start_d = 1'b1;
          kind_d  = cominit_req ? KIND_INIT : KIND_WAKE;
        end
      end
      S_BURST: begin
        if (len_q == BURST_LAST) begin
          state_d = S_GAP;
          len_d   = '0;
        end else begin
          len_d = len_q + LEN_W'(1);
        end
      end
      S_GAP: begin
        if (len_q == gap_last) begin
          len_d = '0;
          if (pair_q == PAIR_LAST) begin
            state_d = S_IDLE;
            pair_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_BURST;
            pair_d  = pair_q + PAIR_W'(1);
          end
        end else begin
          len_d = len_q + LEN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= KIND_INIT;
      start_q     <= 1'b0;
      len_q       <= '0;
      pair_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_elecidle <= 1'b1;
      tx_data     <= '0;
      tx_datak    <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      start_q     <= start_d;
      len_q       <= len_d;
      pair_q      <= pair_d;
      busy        <= (state_d != S_IDLE);
      done        <= done_d;
      tx_elecidle <= (state_d != S_BURST);
      tx_data     <= (state_d == S_BURST) ? ALIGN_DATA : '0;
      tx_datak    <= (state_d == S_BURST) ? ALIGN_DATAK : '0;
    end
  end

endmodule

// File: tb/tb_sata_oob_encoder.sv
// Testbench for sata_oob_encoder at 150 MHz and 75 MHz: table-driven sequence
// measurements, directed reset cases and a randomized run against a timing model.
module tb_sata_oob_encoder;

  localparam int FREQ0 = 150_000;
  localparam int FREQ1 = 75_000;
  localparam int AMT   = 6;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        eid;
    logic [31:0] data;
    logic [3:0]  k;
  } obs_t;

  typedef struct {
    bit init;
    bit wake;
    int late_at;
    int burst0; int gap0; int done0;
    int burst1; int gap1; int done1;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cominit_req = 1'b0;
  logic comwake_req = 1'b0;
  logic        busy0, done0, eid0, busy1, done1, eid1;
  logic [31:0] data0, data1;
  logic [3:0]  k0, k1;
  obs_t        obs [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int cyc = 0;
  int S [2] = '{-1000000, -1000000};
  int T [2] = '{0, 0};

  vec_t vecs [4];

  always #5 clk = ~clk;

  sata_oob_encoder #(.CLKFREQ(FREQ0), .AMOUNT(AMT)) dut0 (
    .clk(clk), .reset(reset), .cominit_req(cominit_req), .comwake_req(comwake_req),
    .busy(busy0), .done(done0), .tx_elecidle(eid0), .tx_data(data0), .tx_datak(k0)
  );

  sata_oob_encoder #(.CLKFREQ(FREQ1), .AMOUNT(AMT)) dut1 (
    .clk(clk), .reset(reset), .cominit_req(cominit_req), .comwake_req(comwake_req),
    .busy(busy1), .done(done1), .tx_elecidle(eid1), .tx_data(data1), .tx_datak(k1)
  );

  assign obs[0] = {busy0, done0, eid0, data0, k0};
  assign obs[1] = {busy1, done1, eid1, data1, k1};

  function automatic int ref_len(input int ui, input int f);
    return (ui * f + 750_000) / 1_500_000;
  endfunction

  function automatic int freq_of(input int d);
    return (d == 0) ? FREQ0 : FREQ1;
  endfunction

  // Model: a sequence accepted at edge k occupies cycles k+1 .. k+T and pulses
  // done at cycle k+1+T; a request is taken only if the previous cycle was idle
  // and no sequence is already waiting to start.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        S[d] = -1000000;
      end else if ((cominit_req || comwake_req) &&
                   !((cyc - 1 >= S[d]) && (cyc - 1 < S[d] + T[d])) && (S[d] != cyc)) begin
        S[d] = cyc + 1;
        T[d] = AMT * (ref_len(160, freq_of(d)) +
                      (cominit_req ? ref_len(480, freq_of(d)) : ref_len(160, freq_of(d))));
      end
    end
  end

  function automatic obs_t model_exp(input int d);
    obs_t e;
    int   off;
    int   per;
    e     = '0;
    e.eid = 1'b1;
    if (!reset) begin
      off = cyc - S[d];
      per = T[d] / AMT;
      if (off >= 0 && off < T[d]) begin
        e.busy = 1'b1;
        if ((off % per) < ref_len(160, freq_of(d))) begin
          e.eid  = 1'b0;
          e.data = 32'h7B4A_4ABC;
          e.k    = 4'b0001;
        end
      end
      e.done = (off == T[d]);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    obs_t e;
    #1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e = model_exp(d);
        checks++;
        if (obs[d] !== e) begin
          errors++;
          $display("FAIL cycle_model dut%0d cyc=%0d got busy=%b done=%b eid=%b data=%h k=%b expected busy=%b done=%b eid=%b data=%h k=%b",
                   d, cyc, obs[d].busy, obs[d].done, obs[d].eid, obs[d].data, obs[d].k,
                   e.busy, e.done, e.eid, e.data, e.k);
        end
      end
    end
  end

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== {1'b0, 1'b0, 1'b1, 32'h0, 4'h0}) begin
        errors++;
        $display("FAIL %s dut%0d got busy=%b done=%b eid=%b data=%h k=%b expected 0 0 1 0 0",
                 name, d, obs[d].busy, obs[d].done, obs[d].eid, obs[d].data, obs[d].k);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   bc [2];
    int   gc [2];
    int   nb [2];
    int   nd [2];
    int   dat [2];
    logic pe [2];
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      bc[d] = 0; gc[d] = 0; nb[d] = 0; nd[d] = 0; dat[d] = -1; pe[d] = 1'b1;
    end
    @(negedge clk);
    cominit_req = v.init;
    comwake_req = v.wake;
    @(negedge clk);
    cominit_req = 1'b0;
    comwake_req = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      comwake_req = (v.late_at > 0) && (c == v.late_at);
      #2;
      for (int d = 0; d < 2; d++) begin
        o = obs[d];
        if (o.busy && !o.eid && o.data == 32'h7B4A_4ABC && o.k == 4'b0001) bc[d]++;
        if (o.busy && o.eid && o.data == 32'h0 && o.k == 4'h0) gc[d]++;
        if (pe[d] && !o.eid) nb[d]++;
        pe[d] = o.eid;
        if (o.done) begin
          nd[d]++;
          if (dat[d] < 0) dat[d] = c;
        end
      end
    end
    check_int({name, " dut0 burst_cycles"}, bc[0], v.burst0);
    check_int({name, " dut0 gap_cycles"},   gc[0], v.gap0);
    check_int({name, " dut0 bursts"},       nb[0], AMT);
    check_int({name, " dut0 done_count"},   nd[0], 1);
    check_int({name, " dut0 done_at"},      dat[0], v.done0);
    check_int({name, " dut1 burst_cycles"}, bc[1], v.burst1);
    check_int({name, " dut1 gap_cycles"},   gc[1], v.gap1);
    check_int({name, " dut1 bursts"},       nb[1], AMT);
    check_int({name, " dut1 done_count"},   nd[1], 1);
    check_int({name, " dut1 done_at"},      dat[1], v.done1);
  endtask

  initial begin
    int r;
    vecs[0] = '{init:1, wake:0, late_at:0,  burst0:96, gap0:288, done0:384, burst1:48, gap1:144, done1:192};
    vecs[1] = '{init:0, wake:1, late_at:0,  burst0:96, gap0:96,  done0:192, burst1:48, gap1:48,  done1:96};
    vecs[2] = '{init:1, wake:1, late_at:0,  burst0:96, gap0:288, done0:384, burst1:48, gap1:144, done1:192};
    vecs[3] = '{init:1, wake:0, late_at:50, burst0:96, gap0:288, done0:384, burst1:48, gap1:144, done1:192};

    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_reset_vals("reset_state");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of the third burst of a COMINIT.
    @(negedge clk);
    cominit_req = 1'b1;
    @(negedge clk);
    cominit_req = 1'b0;
    repeat (132) @(negedge clk);
    #2;
    check_int("mid_reset in_burst busy", int'(busy0), 1);
    check_int("mid_reset in_burst eid",  int'(eid0), 0);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_vec(vecs[1], "after_reset_wake");

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      cominit_req = (r < 3);
      comwake_req = (r >= 2 && r < 5);
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    cominit_req = 1'b0;
    comwake_req = 1'b0;
    reset = 1'b0;
    repeat (450) @(negedge clk);
    #2;
    check_int("final idle busy0", int'(busy0), 0);
    check_int("final idle busy1", int'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
